// File: rtl/mux_output_fifo_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mux_output_fifo_seq
//  Purpose  : First-word-fall-through output FIFO that buffers words from the
//             upstream 2x1 mux stage and presents them to the downstream
//             consumer with a valid/ready handshake.
//  Ports    : clk           - single clock, rising edge
//             rst           - synchronous active-high reset
//             i_valid       - write request (upstream o_valid)
//             i_data_bus    - write data (upstream o_data_bus)
//             i_ready       - consumer accepts the head entry this cycle
//             o_valid       - head entry valid (count != 0)
//             o_data_bus    - head entry data, zero when empty
//             o_full        - count == FIFO_DEPTH
//             o_count       - current occupancy, 0..FIFO_DEPTH
//             o_overflow    - sticky: a write was dropped while full
//  Revision : 1.0 - initial release
// ============================================================================
module mux_output_fifo_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_data_bus,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data_bus,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int                   c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]     c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]     c_CNT_ONE = (c_PTR_W + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A pop frees a slot on the same edge, so a full FIFO can still accept
    // a write when the head is being consumed.
    assign w_pop   = !w_empty && i_ready;
    assign w_push  = i_valid && (!w_full || w_pop);
    assign w_drop  = i_valid && !w_push;

    // Control state: pointers, occupancy and sticky overflow. Pointers are
    // exactly log2(depth) bits wide, so natural binary overflow wraps them
    // from FIFO_DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is left unreset: its contents are masked while empty. Writes
    // are blocked during reset so a word presented then is never kept.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= i_data_bus;
        end
    end

    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_data_bus = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_mux_output_fifo_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_output_fifo_seq
//  Purpose  : Self-checking bench for mux_output_fifo_seq. A queue-based
//             reference tracks the FIFO contents and sticky overflow; every
//             cycle all outputs are compared against it, plus directed
//             constant checks at the interesting points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_output_fifo_seq;

    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    logic                        clk;
    logic                        rst;
    logic                        i_valid;
    logic [DATA_WIDTH-1:0]       i_data_bus;
    logic                        i_ready;
    logic                        o_valid;
    logic [DATA_WIDTH-1:0]       o_data_bus;
    logic                        o_full;
    logic [$clog2(FIFO_DEPTH):0] o_count;
    logic                        o_overflow;

    mux_output_fifo_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the FIFO is just an ordered list of accepted words.
    logic [DATA_WIDTH-1:0] q [$];
    logic                  ref_ovf;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] head;
        head = (q.size() != 0) ? q[0] : 32'h0;
        chk({tag, "_count"}, 32'(o_count), 32'(q.size()));
        chk({tag, "_valid"}, 32'(o_valid), 32'(q.size() != 0));
        chk({tag, "_full"},  32'(o_full),  32'(q.size() == FIFO_DEPTH));
        chk({tag, "_data"},  o_data_bus,   head);
        chk({tag, "_ovf"},   32'(o_overflow), 32'(ref_ovf));
    endtask

    // One clock: drive inputs, let the edge happen, apply the FIFO rules to
    // the reference, then compare 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic rs, input string tag);
        bit pop;
        bit push;
        i_valid    = v;
        i_data_bus = d;
        i_ready    = r;
        rst        = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            ref_ovf = 1'b0;
        end else begin
            pop  = (q.size() != 0) && r;
            push = v && ((q.size() < FIFO_DEPTH) || pop);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(d);
            if (v && !push) ref_ovf = 1'b1;
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ref_ovf    = 1'b0;
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_data_bus = '0;
        i_ready    = 1'b0;

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b1, "rst0");
        step(1'b1, 32'hDEAD, 1'b1, 1'b1, "rst1");
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data",  o_data_bus,   32'h0);

        // Single push, one-cycle latency
        step(1'b1, 32'hA1, 1'b0, 1'b0, "push_a1");
        chk("a1_valid", 32'(o_valid), 32'h1);
        chk("a1_data",  o_data_bus,   32'hA1);
        chk("a1_count", 32'(o_count), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0, "pop_a1");

        // Fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 32'h5, 1'b0, 1'b0, "ovf5");
        chk("ovf_full",  32'(o_full),     32'h1);
        chk("ovf_count", 32'(o_count),    32'h4);
        chk("ovf_flag",  32'(o_overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_head", o_data_bus, 32'(i));
            step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        end
        chk("drained_count", 32'(o_count), 32'h0);

        // Full with simultaneous push and pop
        step(1'b0, 32'h0, 1'b0, 1'b1, "rst_b");
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0, "fill_b");
        step(1'b1, 32'h9, 1'b1, 1'b0, "full_pp");
        chk("fpp_count", 32'(o_count),    32'h4);
        chk("fpp_ovf",   32'(o_overflow), 32'h0);
        chk("fpp_head",  o_data_bus,      32'h2);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain_b");
        chk("fpp_tail_empty", 32'(o_valid), 32'h0);

        // Streaming 20 words with pop every cycle
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0, "stream");
            chk("stream_head", o_data_bus, 32'(i));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, "stream_end");

        // Pop on empty is ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, "empty_pop");
            chk("empty_data", o_data_bus, 32'h0);
        end
        step(1'b1, 32'h33, 1'b0, 1'b0, "after_empty");
        chk("after_empty_data", o_data_bus, 32'h33);
        step(1'b0, 32'h0, 1'b1, 1'b0, "after_empty_pop");

        // Reset with 3 entries and overflow set, concurrent push
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i + 16), 1'b0, 1'b0, "fill_c");
        step(1'b0, 32'h0, 1'b1, 1'b0, "pop_c");
        chk("pre_rst_count", 32'(o_count),    32'h3);
        chk("pre_rst_ovf",   32'(o_overflow), 32'h1);
        step(1'b1, 32'h77, 1'b0, 1'b1, "mid_rst");
        chk("mid_rst_count", 32'(o_count),    32'h0);
        chk("mid_rst_valid", 32'(o_valid),    32'h0);
        chk("mid_rst_ovf",   32'(o_overflow), 32'h0);
        step(1'b1, 32'h55, 1'b0, 1'b0, "post_rst");
        chk("post_rst_head",  o_data_bus,   32'h55);
        chk("post_rst_count", 32'(o_count), 32'h1);

        // Reset while full
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i + 100), 1'b0, 1'b0, "fill_d");
        step(1'b0, 32'h0, 1'b0, 1'b1, "full_rst");
        chk("full_rst_full", 32'(o_full), 32'h0);
        step(1'b1, 32'hBEEF, 1'b0, 1'b0, "post_full_rst");
        chk("post_full_rst_head", o_data_bus, 32'hBEEF);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 59) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
